// File: rtl/writeback_store.sv
// Writeback stage: retires Memory-stage results into the GPR and special register
// files, and issues memory-destination results as two-beat WRITEs on the D-cache bus.
module writeback_store #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned TAG_W  = 13,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validIn,
    input  logic [63:0]       currentRipIn,
    input  logic [31:0]       instructionLengthIn,
    input  logic [3:0]        destRegIn,
    input  logic              destRegValidIn,
    input  logic [63:0]       destRegValueIn,
    input  logic [3:0]        destRegSpecialIn,
    input  logic              destRegSpecialValidIn,
    input  logic              isMemoryAccessDestIn,
    input  logic [63:0]       memoryAddressDestIn,
    output logic              wbStallOut,
    output logic              regWriteEnOut,
    output logic [3:0]        regWriteIdxOut,
    output logic [63:0]       regWriteDataOut,
    output logic              specWriteEnOut,
    output logic [3:0]        specWriteIdxOut,
    output logic [63:0]       specWriteDataOut,
    output logic              retireOut,
    output logic [63:0]       nextRipOut,
    output logic [CNT_W-1:0]  retiredCountOut,
    output logic              reqcyc,
    output logic [ADDR_W-1:0] req,
    output logic [TAG_W-1:0]  reqtag,
    input  logic              reqack,
    input  logic              respcyc,
    input  logic [ADDR_W-1:0] resp,
    output logic              respack
);

    localparam int unsigned RIP_W  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 4;

    // WRITE | MEMORY | DATA in the three tag MSBs, remaining bits zero.
    localparam logic [TAG_W-1:0] WRITE_TAG = {3'b111, {(TAG_W-3){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        DATA      = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    state_t state, stateNext;

    // Store context held until the write completes and the instruction retires.
    logic [DATA_W-1:0] pendData, pendDataNext;
    logic [RIP_W-1:0]  pendRip, pendRipNext;
    logic              pendSpecValid, pendSpecValidNext;
    logic [IDX_W-1:0]  pendSpecIdx, pendSpecIdxNext;

    logic              regWriteEnNext;
    logic [IDX_W-1:0]  regWriteIdxNext;
    logic [DATA_W-1:0] regWriteDataNext;
    logic              specWriteEnNext;
    logic [IDX_W-1:0]  specWriteIdxNext;
    logic [DATA_W-1:0] specWriteDataNext;
    logic              retireNext;
    logic [RIP_W-1:0]  nextRipNext;
    logic [CNT_W-1:0]  retiredCountNext;
    logic              reqcycNext;
    logic [ADDR_W-1:0] reqNext;
    logic [TAG_W-1:0]  reqtagNext;
    logic              respackNext;

    logic [RIP_W-1:0]  acceptRip;
    logic              storeDone;

    // Write responses carry no payload of interest.
    logic unusedResp;
    assign unusedResp = ^resp;

    assign wbStallOut = (state != IDLE);

    // Next-state and next-output logic.
    always_comb begin
        stateNext         = state;
        pendDataNext      = pendData;
        pendRipNext       = pendRip;
        pendSpecValidNext = pendSpecValid;
        pendSpecIdxNext   = pendSpecIdx;
        regWriteEnNext    = 1'b0;
        regWriteIdxNext   = regWriteIdxOut;
        regWriteDataNext  = regWriteDataOut;
        specWriteEnNext   = 1'b0;
        specWriteIdxNext  = specWriteIdxOut;
        specWriteDataNext = specWriteDataOut;
        retireNext        = 1'b0;
        nextRipNext       = nextRipOut;
        retiredCountNext  = retiredCountOut;
        reqcycNext        = reqcyc;
        reqNext           = req;
        reqtagNext        = reqtag;
        respackNext       = 1'b0;
        storeDone         = 1'b0;
        acceptRip         = currentRipIn + RIP_W'(instructionLengthIn);

        case (state)
            IDLE: begin
                if (validIn) begin
                    if (isMemoryAccessDestIn) begin
                        stateNext         = ADDR;
                        pendDataNext      = destRegValueIn;
                        pendRipNext       = acceptRip;
                        pendSpecValidNext = destRegSpecialValidIn;
                        pendSpecIdxNext   = destRegSpecialIn;
                        reqcycNext        = 1'b1;
                        reqNext           = ADDR_W'(memoryAddressDestIn);
                        reqtagNext        = WRITE_TAG;
                    end else begin
                        regWriteEnNext    = destRegValidIn;
                        regWriteIdxNext   = destRegIn;
                        regWriteDataNext  = destRegValueIn;
                        specWriteEnNext   = destRegSpecialValidIn;
                        specWriteIdxNext  = destRegSpecialIn;
                        specWriteDataNext = destRegValueIn;
                        retireNext        = 1'b1;
                        nextRipNext       = acceptRip;
                        retiredCountNext  = retiredCountOut + CNT_W'(1);
                    end
                end
            end
            ADDR: begin
                if (reqack) begin
                    stateNext = DATA;
                    reqNext   = ADDR_W'(pendData);
                end
            end
            DATA: begin
                if (reqack) begin
                    reqcycNext = 1'b0;
                    if (respcyc) begin
                        storeDone = 1'b1;
                    end else begin
                        stateNext = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (respcyc) begin
                    storeDone = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Store completion: acknowledge the response and retire the instruction.
        if (storeDone) begin
            stateNext         = IDLE;
            respackNext       = 1'b1;
            retireNext        = 1'b1;
            specWriteEnNext   = pendSpecValid;
            specWriteIdxNext  = pendSpecIdx;
            specWriteDataNext = pendData;
            nextRipNext       = pendRip;
            retiredCountNext  = retiredCountOut + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pendData         <= '0;
            pendRip          <= '0;
            pendSpecValid    <= 1'b0;
            pendSpecIdx      <= '0;
            regWriteEnOut    <= 1'b0;
            regWriteIdxOut   <= '0;
            regWriteDataOut  <= '0;
            specWriteEnOut   <= 1'b0;
            specWriteIdxOut  <= '0;
            specWriteDataOut <= '0;
            retireOut        <= 1'b0;
            nextRipOut       <= '0;
            retiredCountOut  <= '0;
            reqcyc           <= 1'b0;
            req              <= '0;
            reqtag           <= '0;
            respack          <= 1'b0;
        end else begin
            state            <= stateNext;
            pendData         <= pendDataNext;
            pendRip          <= pendRipNext;
            pendSpecValid    <= pendSpecValidNext;
            pendSpecIdx      <= pendSpecIdxNext;
            regWriteEnOut    <= regWriteEnNext;
            regWriteIdxOut   <= regWriteIdxNext;
            regWriteDataOut  <= regWriteDataNext;
            specWriteEnOut   <= specWriteEnNext;
            specWriteIdxOut  <= specWriteIdxNext;
            specWriteDataOut <= specWriteDataNext;
            retireOut        <= retireNext;
            nextRipOut       <= nextRipNext;
            retiredCountOut  <= retiredCountNext;
            reqcyc           <= reqcycNext;
            req              <= reqNext;
            reqtag           <= reqtagNext;
            respack          <= respackNext;
        end
    end

endmodule

// File: tb/tb_writeback_store.sv
// Scoreboard bench for writeback_store: stimulus queues expected retires and bus beats,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_writeback_store;

    localparam int unsigned TAG_W = 13;
    localparam logic [TAG_W-1:0] WRITE_TAG = 13'h1C00;

    logic        clk;
    logic        reset;
    logic        validIn;
    logic [63:0] currentRipIn;
    logic [31:0] instructionLengthIn;
    logic [3:0]  destRegIn;
    logic        destRegValidIn;
    logic [63:0] destRegValueIn;
    logic [3:0]  destRegSpecialIn;
    logic        destRegSpecialValidIn;
    logic        isMemoryAccessDestIn;
    logic [63:0] memoryAddressDestIn;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;

    logic        wbStallOut, regWriteEnOut, specWriteEnOut, retireOut, reqcyc, respack;
    logic [3:0]  regWriteIdxOut, specWriteIdxOut;
    logic [63:0] regWriteDataOut, specWriteDataOut, nextRipOut, retiredCountOut, req;
    logic [TAG_W-1:0] reqtag;

    logic        wStall, wRegEn, wSpecEn, wRetire, wReqcyc, wRespack;
    logic [3:0]  wRegIdx, wSpecIdx, wCount;
    logic [63:0] wRegData, wSpecData, wNextRip, wReq;
    logic [TAG_W-1:0] wReqtag;

    writeback_store dut (
        .clk(clk), .reset(reset), .validIn(validIn), .currentRipIn(currentRipIn),
        .instructionLengthIn(instructionLengthIn), .destRegIn(destRegIn),
        .destRegValidIn(destRegValidIn), .destRegValueIn(destRegValueIn),
        .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
        .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
        .wbStallOut(wbStallOut), .regWriteEnOut(regWriteEnOut), .regWriteIdxOut(regWriteIdxOut),
        .regWriteDataOut(regWriteDataOut), .specWriteEnOut(specWriteEnOut),
        .specWriteIdxOut(specWriteIdxOut), .specWriteDataOut(specWriteDataOut),
        .retireOut(retireOut), .nextRipOut(nextRipOut), .retiredCountOut(retiredCountOut),
        .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
        .respcyc(respcyc), .resp(resp), .respack(respack)
    );

    // Narrow-counter instance to exercise the all-ones -> 0 wrap in a short run.
    writeback_store #(.CNT_W(4)) wrapDut (
        .clk(clk), .reset(reset), .validIn(validIn), .currentRipIn(currentRipIn),
        .instructionLengthIn(instructionLengthIn), .destRegIn(destRegIn),
        .destRegValidIn(destRegValidIn), .destRegValueIn(destRegValueIn),
        .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
        .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
        .wbStallOut(wStall), .regWriteEnOut(wRegEn), .regWriteIdxOut(wRegIdx),
        .regWriteDataOut(wRegData), .specWriteEnOut(wSpecEn),
        .specWriteIdxOut(wSpecIdx), .specWriteDataOut(wSpecData),
        .retireOut(wRetire), .nextRipOut(wNextRip), .retiredCountOut(wCount),
        .reqcyc(wReqcyc), .req(wReq), .reqtag(wReqtag), .reqack(reqack),
        .respcyc(respcyc), .resp(resp), .respack(wRespack)
    );

    typedef struct {
        logic        regEn;
        logic [3:0]  regIdx;
        logic [63:0] regData;
        logic        specEn;
        logic [3:0]  specIdx;
        logic [63:0] specData;
        logic [63:0] nextRip;
        logic [63:0] count;
        logic        respack;
    } retire_t;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } beat_t;

    retire_t retQ[$];
    beat_t   beatQ[$];
    retire_t monE;
    beat_t   monB;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [63:0] expCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one accept edge and queue its expected effects.
    task automatic sendOp(input logic [63:0] rip, input logic [31:0] len,
                          input logic [3:0] dreg, input logic dval, input logic [63:0] value,
                          input logic [3:0] sreg, input logic sval,
                          input logic isStore, input logic [63:0] addr);
        retire_t e;
        beat_t   b;
        validIn = 1'b1;
        currentRipIn = rip;
        instructionLengthIn = len;
        destRegIn = dreg;
        destRegValidIn = dval;
        destRegValueIn = value;
        destRegSpecialIn = sreg;
        destRegSpecialValidIn = sval;
        isMemoryAccessDestIn = isStore;
        memoryAddressDestIn = addr;
        expCount = expCount + 64'd1;
        e.regEn = dval & ~isStore;
        e.regIdx = dreg;
        e.regData = value;
        e.specEn = sval;
        e.specIdx = sreg;
        e.specData = value;
        e.nextRip = rip + 64'(len);
        e.count = expCount;
        e.respack = isStore;
        retQ.push_back(e);
        if (isStore) begin
            b.data = addr;
            b.tag = WRITE_TAG;
            beatQ.push_back(b);
            b.data = value;
            beatQ.push_back(b);
        end
        tick();
        validIn = 1'b0;
        isMemoryAccessDestIn = 1'b0;
    endtask

    // Monitor: compares every retire pulse and every accepted bus beat against the queues.
    always @(negedge clk) begin
        if (retireOut === 1'b1) begin
            if (retQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_retire: got retire=1 expected no retire at %0t", $time);
            end else begin
                monE = retQ.pop_front();
                check("retire.regWriteEn", 64'(regWriteEnOut), 64'(monE.regEn));
                if (monE.regEn) begin
                    check("retire.regWriteIdx", 64'(regWriteIdxOut), 64'(monE.regIdx));
                    check("retire.regWriteData", regWriteDataOut, monE.regData);
                end
                check("retire.specWriteEn", 64'(specWriteEnOut), 64'(monE.specEn));
                if (monE.specEn) begin
                    check("retire.specWriteIdx", 64'(specWriteIdxOut), 64'(monE.specIdx));
                    check("retire.specWriteData", specWriteDataOut, monE.specData);
                end
                check("retire.nextRip", nextRipOut, monE.nextRip);
                check("retire.count", retiredCountOut, monE.count);
                check("retire.respack", 64'(respack), 64'(monE.respack));
            end
        end else if (regWriteEnOut === 1'b1 || specWriteEnOut === 1'b1 || respack === 1'b1) begin
            nChecks++;
            nFail++;
            $display("FAIL stray_strobe: got regEn=%0b specEn=%0b respack=%0b expected 0 without retire at %0t",
                     regWriteEnOut, specWriteEnOut, respack, $time);
        end
        if (reqcyc === 1'b1 && reqack === 1'b1) begin
            if (beatQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_beat: got req=0x%0h expected no beat at %0t", req, $time);
            end else begin
                monB = beatQ.pop_front();
                check("beat.req", req, monB.data);
                check("beat.reqtag", 64'(reqtag), 64'(monB.tag));
            end
        end
    end

    initial begin
        reset = 1'b1;
        validIn = 1'b0;
        currentRipIn = '0;
        instructionLengthIn = '0;
        destRegIn = '0;
        destRegValidIn = 1'b0;
        destRegValueIn = '0;
        destRegSpecialIn = '0;
        destRegSpecialValidIn = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressDestIn = '0;
        reqack = 1'b0;
        respcyc = 1'b0;
        resp = '0;
        expCount = '0;

        repeat (2) tick();
        check("reset.stall", 64'(wbStallOut), 64'd0);
        check("reset.strobes", 64'({regWriteEnOut, specWriteEnOut, retireOut, reqcyc, respack}), 64'd0);
        check("reset.nextRip", nextRipOut, 64'd0);
        check("reset.req", req, 64'd0);
        check("reset.reqtag", 64'(reqtag), 64'd0);
        check("reset.count", retiredCountOut, 64'd0);
        reset = 1'b0;
        tick();

        // GPR write and retire.
        sendOp(64'h1000, 32'd3, 4'd3, 1'b1, 64'hDEAD, 4'd0, 1'b0, 1'b0, 64'h0);
        check("t1.nextRip", nextRipOut, 64'h1003);
        check("t1.count", retiredCountOut, 64'd1);
        check("t1.stall", 64'(wbStallOut), 64'd0);
        tick();
        check("t1.retireDrop", 64'(retireOut), 64'd0);

        // Store with delayed reqack on each beat and a late response.
        sendOp(64'h1003, 32'd4, 4'd5, 1'b1, 64'h55, 4'd2, 1'b1, 1'b1, 64'h2000);
        for (int i = 0; i < 2; i++) begin
            check("t2.addrReqcyc", 64'(reqcyc), 64'd1);
            check("t2.addrReq", req, 64'h2000);
            check("t2.addrStall", 64'(wbStallOut), 64'd1);
            tick();
        end
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2.dataReqcyc", 64'(reqcyc), 64'd1);
            check("t2.dataReq", req, 64'h55);
            check("t2.dataStall", 64'(wbStallOut), 64'd1);
            tick();
        end
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2.waitReqcyc", 64'(reqcyc), 64'd0);
            check("t2.waitStall", 64'(wbStallOut), 64'd1);
            tick();
        end
        respcyc = 1'b1;
        tick();
        respcyc = 1'b0;
        check("t2.respack", 64'(respack), 64'd1);
        check("t2.retire", 64'(retireOut), 64'd1);
        check("t2.noGprWrite", 64'(regWriteEnOut), 64'd0);
        check("t2.stallClear", 64'(wbStallOut), 64'd0);
        tick();
        check("t2.respackDrop", 64'(respack), 64'd0);
        check("t2.retireDrop", 64'(retireOut), 64'd0);

        // Four back-to-back non-stores.
        sendOp(64'h3000, 32'd1, 4'd1, 1'b1, 64'h11, 4'd0, 1'b0, 1'b0, 64'h0);
        check("t3.retire0", 64'(retireOut), 64'd1);
        check("t3.stall0", 64'(wbStallOut), 64'd0);
        sendOp(64'h3001, 32'd2, 4'd2, 1'b0, 64'h22, 4'd7, 1'b1, 1'b0, 64'h0);
        check("t3.retire1", 64'(retireOut), 64'd1);
        check("t3.stall1", 64'(wbStallOut), 64'd0);
        sendOp(64'h3003, 32'd15, 4'd14, 1'b1, 64'h33, 4'd9, 1'b1, 1'b0, 64'h0);
        check("t3.retire2", 64'(retireOut), 64'd1);
        check("t3.stall2", 64'(wbStallOut), 64'd0);
        sendOp(64'h3012, 32'd5, 4'd15, 1'b1, 64'h44, 4'd0, 1'b0, 1'b0, 64'h0);
        check("t3.retire3", 64'(retireOut), 64'd1);
        check("t3.stall3", 64'(wbStallOut), 64'd0);
        check("t3.count", retiredCountOut, 64'd6);
        tick();

        // Store completing with reqack and respcyc together in DATA; early respcyc ignored.
        sendOp(64'h4000, 32'd2, 4'd4, 1'b0, 64'hCAFE, 4'd1, 1'b0, 1'b1, 64'h8000);
        respcyc = 1'b1;
        tick();
        respcyc = 1'b0;
        check("t4.earlyResp", 64'(respack), 64'd0);
        reqack = 1'b1;
        tick();
        check("t4.dataReq", req, 64'hCAFE);
        respcyc = 1'b1;
        tick();
        reqack = 1'b0;
        respcyc = 1'b0;
        check("t4.respack", 64'(respack), 64'd1);
        check("t4.retire", 64'(retireOut), 64'd1);
        check("t4.reqcyc", 64'(reqcyc), 64'd0);
        check("t4.stallClear", 64'(wbStallOut), 64'd0);
        tick();
        check("t4.respackDrop", 64'(respack), 64'd0);
        check("t4.retireDrop", 64'(retireOut), 64'd0);

        // Reset while the data beat is pending aborts the store.
        sendOp(64'h5000, 32'd4, 4'd0, 1'b0, 64'h77, 4'd0, 1'b0, 1'b1, 64'h9000);
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        check("t5.inData", 64'(reqcyc), 64'd1);
        reset = 1'b1;
        retQ.delete();
        beatQ.delete();
        expCount = '0;
        tick();
        reset = 1'b0;
        check("t5.reqcyc", 64'(reqcyc), 64'd0);
        check("t5.stall", 64'(wbStallOut), 64'd0);
        check("t5.count", retiredCountOut, 64'd0);
        tick();
        sendOp(64'h6000, 32'd2, 4'd6, 1'b1, 64'h66, 4'd0, 1'b0, 1'b0, 64'h0);
        check("t5.afterReset", retiredCountOut, 64'd1);

        // RIP wraparound, then counter wrap on the narrow instance.
        sendOp(64'hFFFF_FFFF_FFFF_FFFE, 32'd4, 4'd8, 1'b1, 64'h88, 4'd0, 1'b0, 1'b0, 64'h0);
        check("t6.nextRipWrap", nextRipOut, 64'h2);
        while (expCount < 64'd16) begin
            sendOp(64'h7000, 32'd1, 4'd9, 1'b1, expCount, 4'd0, 1'b0, 1'b0, 64'h0);
            check("t6.wrapCount", 64'(wCount), 64'(expCount[3:0]));
        end
        check("t6.wrapZero", 64'(wCount), 64'd0);
        check("t6.wideCount", retiredCountOut, 64'd16);

        repeat (3) tick();
        check("end.retQEmpty", 64'(retQ.size()), 64'd0);
        check("end.beatQEmpty", 64'(beatQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
